// File: rtl/seg7_bcd_scan_pkg.sv
// Shared types, segment constants and the 7-segment glyph table for seg7_bcd_scan.
package seg7_bcd_scan_pkg;

  // Conversion control states: wait for a request, run the serial engine, commit result.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  // Segment bytes are {dp,g,f,e,d,c,b,a}, active-high before output polarity is applied.
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DASH  = 8'h40;
  localparam int         SEG_DP    = 7;

  // BCD digit to {g,f,e,d,c,b,a}; non-decimal codes are blanked.
  function automatic logic [6:0] glyph(input logic [3:0] bcd);
    logic [6:0] g;
    case (bcd)
      4'd0:    g = 7'h3F;
      4'd1:    g = 7'h06;
      4'd2:    g = 7'h5B;
      4'd3:    g = 7'h4F;
      4'd4:    g = 7'h66;
      4'd5:    g = 7'h6D;
      4'd6:    g = 7'h7D;
      4'd7:    g = 7'h07;
      4'd8:    g = 7'h7F;
      4'd9:    g = 7'h6F;
      default: g = 7'h00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_bcd_scan_if.sv
// Request/ready handshake carrying the binary measurement into seg7_bcd_scan.
interface seg7_bcd_scan_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              ready;

  modport master (output data_in, output data_valid, input ready);
  modport slave  (input data_in, input data_valid, output ready);
endinterface

// File: rtl/seg7_bcd_scan_bcd_dd_conv.sv
// Serial double-dabble binary-to-BCD engine: one add-3/shift step per clock.
module bcd_dd_conv #(
  parameter int DATA_W = 16,
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [DATA_W-1:0]   bin_i,
  output logic                done_o,
  output logic [4*DIGITS-1:0] bcd_o,
  output logic                ovf_o
);

  localparam int NBCD = (DATA_W + 2) / 3;
  localparam int BW   = 4 * NBCD;
  localparam int CW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] bin_q, bin_d;
  logic [BW-1:0]     bcd_q, bcd_d, adj_s;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;

  // Add 3 to every nibble that would reach 10 or more after the next doubling.
  always_comb begin
    adj_s = bcd_q;
    for (int n = 0; n < NBCD; n++) begin
      if (bcd_q[4*n +: 4] >= 4'd5) begin
        adj_s[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
      end else begin
        adj_s[4*n +: 4] = bcd_q[4*n +: 4];
      end
    end
  end

  // Load on start, then shift the binary MSB into the adjusted BCD word DATA_W times.
  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start_i) begin
      bin_d  = bin_i;
      bcd_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      bcd_d = BW'({adj_s, bin_q[DATA_W-1]});
      bin_d = {bin_q[DATA_W-2:0], 1'b0};
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(DATA_W - 1)) begin
        busy_d = 1'b0;
      end else begin
        busy_d = 1'b1;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Engine state registers; reset abandons any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // High during the final shift, so bcd_o is complete from the next cycle on.
  assign done_o = busy_q && (cnt_q == CW'(DATA_W - 1));

  // Present the low DIGITS nibbles, zero-extending when the engine is narrower.
  for (genvar i = 0; i < DIGITS; i++) begin : g_out
    if (i < NBCD) begin : g_dig
      assign bcd_o[4*i +: 4] = bcd_q[4*i +: 4];
    end else begin : g_zero
      assign bcd_o[4*i +: 4] = 4'd0;
    end
  end

  // Any nonzero nibble beyond the displayed digits means the value does not fit.
  if (NBCD > DIGITS) begin : g_ovf
    assign ovf_o = |bcd_q[BW-1:4*DIGITS];
  end else begin : g_no_ovf
    assign ovf_o = 1'b0;
  end

endmodule

// File: rtl/seg7_bcd_scan.sv
// N-digit 7-segment driver: serial BCD conversion, blanking, fixed dp, dashes and scanning.
module seg7_bcd_scan
  import seg7_bcd_scan_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int DIGITS      = 4,
  parameter int FRAC_DIGITS = 1,
  parameter int SCAN_DIV    = 100000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                clk100MHz,
  input  logic                rst_n,
  seg7_bcd_scan_if.slave      bus,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                overflow,
  output logic [7:0]          seg_out,
  output logic [DIGITS-1:0]   dig_en,
  output logic [8*DIGITS-1:0] static_segs
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = $clog2(DIGITS);

  // Output polarity masks, applied only at the output registers.
  localparam logic [7:0]          SEG_INV  = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0]   DIG_INV  = {DIGITS{(ACTIVE_LOW != 0)}};
  localparam logic [8*DIGITS-1:0] STAT_INV = {DIGITS{SEG_INV}};

  state_e                state_q;
  logic                  ready_q;
  logic [4*DIGITS-1:0]   bcd_q;
  logic                  ovf_q;
  logic [8*DIGITS-1:0]   disp_q, disp_d;
  logic [CNT_W-1:0]      scan_cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic [7:0]            seg_q, cur_seg_s;
  logic [DIGITS-1:0]     dig_q, onehot_s;
  logic [8*DIGITS-1:0]   static_q;

  logic                  start_s;
  logic                  conv_done_s;
  logic [4*DIGITS-1:0]   conv_bcd_s;
  logic                  conv_ovf_s;

  assign start_s   = bus.data_valid & ready_q;
  assign bus.ready = ready_q;

  bcd_dd_conv #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk     (clk100MHz),
    .rst_n   (rst_n),
    .start_i (start_s),
    .bin_i   (bus.data_in),
    .done_o  (conv_done_s),
    .bcd_o   (conv_bcd_s),
    .ovf_o   (conv_ovf_s)
  );

  // Build the display image from the finished conversion: dashes, blanking, glyphs and dp.
  always_comb begin
    logic nz;
    nz     = 1'b0;
    disp_d = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz = nz | (conv_bcd_s[4*i +: 4] != 4'd0);
      if (conv_ovf_s) begin
        disp_d[8*i +: 8] = SEG_DASH;
      end else if ((i > FRAC_DIGITS) && !nz) begin
        disp_d[8*i +: 8] = SEG_BLANK;
      end else begin
        disp_d[8*i +: 8] = {((FRAC_DIGITS > 0) && (i == FRAC_DIGITS)), glyph(conv_bcd_s[4*i +: 4])};
      end
    end
  end

  // Conversion FSM; the result, overflow flag and display image are committed together.
  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      disp_q  <= {DIGITS{SEG_BLANK}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_s) begin
            state_q <= ST_SHIFT;
            ready_q <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (conv_done_s) begin
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          bcd_q   <= conv_bcd_s;
          ovf_q   <= conv_ovf_s;
          disp_q  <= disp_d;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Free-running slot counter and digit index; conversions never disturb the scan.
  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
    end else if (scan_cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      scan_cnt_q <= '0;
      if (idx_q == IDX_W'(DIGITS - 1)) begin
        idx_q <= '0;
      end else begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end else begin
      scan_cnt_q <= scan_cnt_q + CNT_W'(1);
    end
  end

  // Select the current digit's segments and its one-hot enable.
  always_comb begin
    cur_seg_s = SEG_BLANK;
    onehot_s  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_seg_s   = disp_q[8*i +: 8];
        onehot_s[i] = 1'b1;
      end else begin
        onehot_s[i] = 1'b0;
      end
    end
  end

  // Output registers with polarity applied; reset leaves every output inactive.
  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      seg_q    <= SEG_INV;
      dig_q    <= DIG_INV;
      static_q <= STAT_INV;
    end else begin
      seg_q    <= cur_seg_s ^ SEG_INV;
      dig_q    <= onehot_s ^ DIG_INV;
      static_q <= disp_q ^ STAT_INV;
    end
  end

  assign bcd_out     = bcd_q;
  assign overflow    = ovf_q;
  assign seg_out     = seg_q;
  assign dig_en      = dig_q;
  assign static_segs = static_q;

endmodule

// File: tb/tb_seg7_bcd_scan.sv
// Self-checking bench for seg7_bcd_scan against a decimal-arithmetic reference model.
module tb_seg7_bcd_scan;

  localparam int DATA_W   = 16;
  localparam int DIGITS   = 4;
  localparam int FRAC     = 1;
  localparam int SCAN_DIV = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  seg7_bcd_scan_if #(.DATA_W(DATA_W)) bus ();
  seg7_bcd_scan_if #(.DATA_W(DATA_W)) bus_al ();

  logic [15:0] bcd_out, bcd_out_al;
  logic        overflow, overflow_al;
  logic [7:0]  seg_out, seg_out_al;
  logic [3:0]  dig_en, dig_en_al;
  logic [31:0] static_segs, static_segs_al;

  seg7_bcd_scan #(
    .DATA_W(DATA_W), .DIGITS(DIGITS), .FRAC_DIGITS(FRAC), .SCAN_DIV(SCAN_DIV), .ACTIVE_LOW(0)
  ) dut (
    .clk100MHz(clk), .rst_n(rst_n), .bus(bus), .bcd_out(bcd_out), .overflow(overflow),
    .seg_out(seg_out), .dig_en(dig_en), .static_segs(static_segs)
  );

  seg7_bcd_scan #(
    .DATA_W(DATA_W), .DIGITS(DIGITS), .FRAC_DIGITS(FRAC), .SCAN_DIV(SCAN_DIV), .ACTIVE_LOW(1)
  ) dut_al (
    .clk100MHz(clk), .rst_n(rst_n), .bus(bus_al), .bcd_out(bcd_out_al), .overflow(overflow_al),
    .seg_out(seg_out_al), .dig_en(dig_en_al), .static_segs(static_segs_al)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [6:0] glyph_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] model_bcd(input int v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic logic [31:0] model_static(input int v);
    logic [31:0] r;
    int d;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d = (v / pow10(i)) % 10;
      if (v >= pow10(DIGITS)) r[8*i +: 8] = 8'h40;
      else if (i > FRAC && v < pow10(i)) r[8*i +: 8] = 8'h00;
      else r[8*i +: 8] = {(i == FRAC) ? 1'b1 : 1'b0, glyph_tab[d]};
    end
    return r;
  endfunction

  // Starts at a negedge; issues one request and counts negedges with ready low.
  task automatic convert(input int v, output int low_cycles);
    int t;
    t = 0;
    while (bus.ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    bus.data_in    = 16'(v);
    bus.data_valid = 1'b1;
    @(posedge clk);
    #1 bus.data_valid = 1'b0;
    low_cycles = 0;
    @(negedge clk);
    while (bus.ready === 1'b0 && low_cycles < 100) begin
      low_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic run_value(input int v, input string tag);
    int lc;
    convert(v, lc);
    check({tag, "_ready_low"}, 64'(lc), 64'd17);
    @(negedge clk);
    check({tag, "_bcd"}, 64'(bcd_out), 64'(model_bcd(v)));
    check({tag, "_ovf"}, 64'(overflow), 64'(v >= pow10(DIGITS)));
    check({tag, "_static"}, 64'(static_segs), 64'(model_static(v)));
  endtask

  initial begin
    int t;
    int v;
    logic [3:0] prev;
    logic [31:0] exp_s;

    bus.data_in = '0;  bus.data_valid = 1'b0;
    bus_al.data_in = '0; bus_al.data_valid = 1'b0;

    // 1: asynchronous reset, checked before any clock edge
    #1 rst_n = 1'b0;
    #2;
    check("rst_ready", 64'(bus.ready), 64'd1);
    check("rst_bcd", 64'(bcd_out), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_seg", 64'(seg_out), 64'h00);
    check("rst_dig", 64'(dig_en), 64'h0);
    check("rst_static", 64'(static_segs), 64'd0);
    check("rst_al_seg", 64'(seg_out_al), 64'hFF);
    check("rst_al_dig", 64'(dig_en_al), 64'hF);
    check("rst_al_static", 64'(static_segs_al), 64'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 2, 3: directed values with literal glyph expectations
    run_value(235, "v235");
    check("v235_lit", 64'(static_segs), 64'h005B_CF6D);
    run_value(5, "v5");
    check("v5_lit", 64'(static_segs), 64'h0000_BF6D);

    // 4: overflow boundary
    run_value(10000, "v10000");
    check("v10000_lit", 64'(static_segs), 64'h4040_4040);
    run_value(9999, "v9999");
    check("v9999_lit", 64'(bcd_out), 64'h9999);
    run_value(0, "v0");

    // 5: request while busy is dropped
    bus.data_in = 16'd100;
    bus.data_valid = 1'b1;
    @(posedge clk);
    #1 bus.data_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    bus.data_in = 16'd200;
    bus.data_valid = 1'b1;
    @(posedge clk);
    #1 bus.data_valid = 1'b0;
    t = 0;
    while (bus.ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drop_ready_timeout", 64'(t < 100), 64'd1);
    repeat (3) @(negedge clk);
    check("drop_ready_stays", 64'(bus.ready), 64'd1);
    check("drop_bcd", 64'(bcd_out), 64'h0100);
    check("drop_static", 64'(static_segs), 64'(model_static(100)));

    // 5: scan order and slot length
    exp_s = model_static(100);
    prev = dig_en;
    t = 0;
    @(negedge clk);
    while (!(dig_en == 4'b0001 && prev != 4'b0001) && t < 50) begin
      prev = dig_en;
      @(negedge clk);
      t++;
    end
    check("scan_sync", 64'(t < 50), 64'd1);
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < SCAN_DIV; c++) begin
        check("scan_dig", 64'(dig_en), 64'(4'b0001 << (k % DIGITS)));
        check("scan_seg", 64'(seg_out), 64'(exp_s[8*(k % DIGITS) +: 8]));
        @(negedge clk);
      end
    end

    // Randomized values against the reference model
    for (int i = 0; i < 8; i++) begin
      v = (i % 2 == 1) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 65535));
      run_value(v, "rand");
    end

    // 6: reset mid-conversion
    run_value(42, "pre_rst");
    bus.data_in = 16'd4321;
    bus.data_valid = 1'b1;
    @(posedge clk);
    #1 bus.data_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 64'(bus.ready), 64'd1);
    check("mid_rst_bcd", 64'(bcd_out), 64'd0);
    check("mid_rst_ovf", 64'(overflow), 64'd0);
    check("mid_rst_seg", 64'(seg_out), 64'h00);
    check("mid_rst_dig", 64'(dig_en), 64'h0);
    check("mid_rst_static", 64'(static_segs), 64'd0);
    check("mid_rst_al_seg", 64'(seg_out_al), 64'hFF);
    check("mid_rst_al_dig", 64'(dig_en_al), 64'hF);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check("post_rst_bcd", 64'(bcd_out), 64'd0);
    check("post_rst_static", 64'(static_segs), 64'd0);
    check("post_rst_ready", 64'(bus.ready), 64'd1);
    run_value(4321, "v4321");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
